// File: rtl/aclk_ld_pkg.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_ld_pkg
//  Description : Shared types and constants for the alarm-clock load arbiter.
//                Defines the request word, response codes, FSM states and the
//                BCD time range helper.
//  Revision    : 1.0 - initial release
// ============================================================================
package aclk_ld_pkg;

    // Default cycle budget in VERIFY before a time load is declared failed
    localparam int unsigned c_timeout_cyc_def = 15;
    // Width of the VERIFY cycle counter
    localparam int unsigned c_cnt_w           = 5;

    // Load request word: alarm selects the alarm registers, otherwise clock time
    typedef struct packed {
        logic       alarm;
        logic [1:0] h1;
        logic [3:0] h0;
        logic [3:0] m1;
        logic [3:0] m0;
    } aclk_ld_req_t;

    typedef enum logic [1:0] {
        LD_OK      = 2'd0,
        LD_RANGE   = 2'd1,
        LD_TIMEOUT = 2'd2
    } aclk_ld_code_t;

    typedef enum logic [2:0] {
        ST_IDLE   = 3'd0,
        ST_CHECK  = 3'd1,
        ST_LOAD   = 3'd2,
        ST_VERIFY = 3'd3,
        ST_RESP   = 3'd4
    } aclk_ld_state_t;

    // True when the request holds a legal 24-hour BCD time (00:00 .. 23:59)
    function automatic logic bcd_time_ok(input aclk_ld_req_t r);
        logic v_ok;
        v_ok = (r.h1 <= 2'd2) && (r.h0 <= 4'd9) && (r.m1 <= 4'd5) && (r.m0 <= 4'd9);
        if ((r.h1 == 2'd2) && (r.h0 > 4'd3)) begin
            v_ok = 1'b0;
        end
        return v_ok;
    endfunction

endpackage
`default_nettype wire

// File: rtl/aclk_rr_arb2.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_rr_arb2
//  Description : Two-requester round-robin arbiter. A lone requester always
//                wins; on a tie the pointer decides. After any grant the
//                pointer moves to the requester that was not granted.
//  Revision    : 1.0 - initial release
// ============================================================================
module aclk_rr_arb2 (
    input  logic       clk,
    input  logic       rst,
    input  logic       i_en,
    input  logic [1:0] i_req,
    output logic [1:0] o_gnt,
    output logic       o_gnt_idx
);

    logic       r_ptr;
    logic [1:0] w_gnt;
    logic       w_idx;

    // Grant decision: single requester wins outright, tie resolved by pointer
    always_comb begin
        w_gnt = 2'b00;
        w_idx = 1'b0;
        if (i_en) begin
            case (i_req)
                2'b01: begin
                    w_gnt = 2'b01;
                    w_idx = 1'b0;
                end
                2'b10: begin
                    w_gnt = 2'b10;
                    w_idx = 1'b1;
                end
                2'b11: begin
                    w_idx = r_ptr;
                    w_gnt = r_ptr ? 2'b10 : 2'b01;
                end
                default: begin
                    w_gnt = 2'b00;
                    w_idx = 1'b0;
                end
            endcase
        end
    end

    // Pointer always moves to the other requester after a grant
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_ptr <= 1'b0;
        end else if (|w_gnt) begin
            r_ptr <= ~w_idx;
        end
    end

    assign o_gnt     = w_gnt;
    assign o_gnt_idx = w_idx;

endmodule
`default_nettype wire

// File: rtl/aclk_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : aclk_load_arbiter
//  Description : Arbitrates time/alarm load requests from two requesters,
//                range-checks the BCD value, pulses the alarm-clock load
//                strobe and, for time loads, verifies the readback before
//                returning a completion code to the granted requester.
//  Revision    : 1.0 - initial release
// ============================================================================
module aclk_load_arbiter
    import aclk_ld_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYC = c_timeout_cyc_def
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         req_valid0,
    input  logic         req_valid1,
    input  aclk_ld_req_t req_data0,
    input  aclk_ld_req_t req_data1,
    output logic [1:0]   req_ready,
    output logic [1:0]   resp_valid,
    output logic [1:0]   resp_code,
    output logic [1:0]   H_in1,
    output logic [3:0]   H_in0,
    output logic [3:0]   M_in1,
    output logic [3:0]   M_in0,
    output logic         LD_time,
    output logic         LD_alarm,
    input  logic [1:0]   H_out1,
    input  logic [3:0]   H_out0,
    input  logic [3:0]   M_out1,
    input  logic [3:0]   M_out0,
    output logic         busy
);

    // Last VERIFY cycle index before a mismatch becomes a timeout
    localparam logic [c_cnt_w-1:0] c_cnt_last = c_cnt_w'(TIMEOUT_CYC - 1);

    aclk_ld_state_t       r_state;
    aclk_ld_state_t       w_state_nxt;
    aclk_ld_req_t         r_req;
    logic                 r_idx;
    aclk_ld_code_t        r_code;
    aclk_ld_code_t        w_code_nxt;
    logic [c_cnt_w-1:0]   r_cnt;
    logic [1:0]           w_gnt;
    logic                 w_gnt_idx;
    logic                 w_arb_en;
    logic                 w_match;
    logic                 w_range_ok;

    // Accepts only happen in IDLE and never while reset is held, so
    // req_ready drops asynchronously with reset despite being combinational
    assign w_arb_en   = (r_state == ST_IDLE) && !reset;
    assign w_range_ok = bcd_time_ok(r_req);
    assign w_match    = (H_out1 == r_req.h1) && (H_out0 == r_req.h0) &&
                        (M_out1 == r_req.m1) && (M_out0 == r_req.m0);

    aclk_rr_arb2 u_arb (
        .clk       (clk),
        .rst       (reset),
        .i_en      (w_arb_en),
        .i_req     ({req_valid1, req_valid0}),
        .o_gnt     (w_gnt),
        .o_gnt_idx (w_gnt_idx)
    );

    assign req_ready = w_gnt;

    // State register
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Captured request, owner, pending code and VERIFY cycle counter
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_req  <= '0;
            r_idx  <= 1'b0;
            r_code <= LD_OK;
            r_cnt  <= '0;
        end else begin
            if (|w_gnt) begin
                r_req <= w_gnt_idx ? req_data1 : req_data0;
                r_idx <= w_gnt_idx;
            end
            r_code <= w_code_nxt;
            // Counter runs only inside VERIFY, so it is zero on every entry
            r_cnt  <= (r_state == ST_VERIFY) ? (r_cnt + 1'b1) : '0;
        end
    end

    // Next-state and output decode
    always_comb begin
        w_state_nxt = r_state;
        w_code_nxt  = r_code;
        resp_valid  = 2'b00;
        resp_code   = 2'b00;
        H_in1       = '0;
        H_in0       = '0;
        M_in1       = '0;
        M_in0       = '0;
        LD_time     = 1'b0;
        LD_alarm    = 1'b0;
        busy        = (r_state != ST_IDLE);
        case (r_state)
            ST_IDLE: begin
                if (|w_gnt) begin
                    w_state_nxt = ST_CHECK;
                end
            end
            ST_CHECK: begin
                if (w_range_ok) begin
                    w_state_nxt = ST_LOAD;
                end else begin
                    w_state_nxt = ST_RESP;
                    w_code_nxt  = LD_RANGE;
                end
            end
            ST_LOAD: begin
                H_in1 = r_req.h1;
                H_in0 = r_req.h0;
                M_in1 = r_req.m1;
                M_in0 = r_req.m0;
                if (r_req.alarm) begin
                    LD_alarm    = 1'b1;
                    w_state_nxt = ST_RESP;
                    w_code_nxt  = LD_OK;
                end else begin
                    LD_time     = 1'b1;
                    w_state_nxt = ST_VERIFY;
                end
            end
            ST_VERIFY: begin
                H_in1 = r_req.h1;
                H_in0 = r_req.h0;
                M_in1 = r_req.m1;
                M_in0 = r_req.m0;
                if (w_match) begin
                    w_state_nxt = ST_RESP;
                    w_code_nxt  = LD_OK;
                end else if (r_cnt == c_cnt_last) begin
                    w_state_nxt = ST_RESP;
                    w_code_nxt  = LD_TIMEOUT;
                end
            end
            ST_RESP: begin
                resp_valid[r_idx] = 1'b1;
                resp_code         = r_code;
                w_state_nxt       = ST_IDLE;
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

endmodule
`default_nettype wire

// File: tb/tb_aclk_load_arbiter.sv
`default_nettype none
// ============================================================================
//  Module      : tb_aclk_load_arbiter
//  Description : Directed self-checking bench for aclk_load_arbiter.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_aclk_load_arbiter;

    localparam int unsigned TIMEOUT = 15;

    logic        clk = 1'b0;
    logic        reset = 1'b1;
    logic        req_valid0 = 1'b0;
    logic        req_valid1 = 1'b0;
    logic [14:0] req_data0 = '0;
    logic [14:0] req_data1 = '0;
    logic [1:0]  req_ready;
    logic [1:0]  resp_valid;
    logic [1:0]  resp_code;
    logic [1:0]  H_in1;
    logic [3:0]  H_in0;
    logic [3:0]  M_in1;
    logic [3:0]  M_in0;
    logic        LD_time;
    logic        LD_alarm;
    logic [1:0]  H_out1 = '0;
    logic [3:0]  H_out0 = '0;
    logic [3:0]  M_out1 = '0;
    logic [3:0]  M_out0 = '0;
    logic        busy;

    int n_vec = 0;
    int n_err = 0;

    aclk_load_arbiter #(.TIMEOUT_CYC(TIMEOUT)) dut (
        .clk        (clk),
        .reset      (reset),
        .req_valid0 (req_valid0),
        .req_valid1 (req_valid1),
        .req_data0  (req_data0),
        .req_data1  (req_data1),
        .req_ready  (req_ready),
        .resp_valid (resp_valid),
        .resp_code  (resp_code),
        .H_in1      (H_in1),
        .H_in0      (H_in0),
        .M_in1      (M_in1),
        .M_in0      (M_in0),
        .LD_time    (LD_time),
        .LD_alarm   (LD_alarm),
        .H_out1     (H_out1),
        .H_out0     (H_out0),
        .M_out1     (M_out1),
        .M_out0     (M_out0),
        .busy       (busy)
    );

    always #5 clk = ~clk;

    function automatic logic [14:0] mk(input logic a, input logic [1:0] h1,
                                       input logic [3:0] h0, input logic [3:0] m1,
                                       input logic [3:0] m0);
        return {a, h1, h0, m1, m0};
    endfunction

    // Advance to 2 time units after the next rising edge
    task automatic tick();
        @(posedge clk);
        #2;
    endtask

    task automatic apply_reset();
        reset = 1'b1;
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        req_data0 = '0; req_data1 = '0;
        H_out1 = '0; H_out0 = '0; M_out1 = '0; M_out0 = '0;
        tick();
        tick();
        reset = 1'b0;
        #1;
    endtask

    task automatic test_reset();
        reset = 1'b1;
        req_valid0 = 1'b1; req_valid1 = 1'b1;
        req_data0 = mk(1'b0, 2'd1, 4'd2, 4'd3, 4'd4);
        req_data1 = mk(1'b0, 2'd1, 4'd2, 4'd3, 4'd4);
        tick();
        #1;
        n_vec++;
        if (req_ready !== 2'b00) begin n_err++; $display("FAIL reset_ready: got %b want 00", req_ready); end
        n_vec++;
        if ({resp_valid, resp_code} !== 4'b0000) begin n_err++; $display("FAIL reset_resp: got %b want 0000", {resp_valid, resp_code}); end
        n_vec++;
        if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin n_err++; $display("FAIL reset_hm: got %h want 0", {H_in1, H_in0, M_in1, M_in0}); end
        n_vec++;
        if ({LD_time, LD_alarm, busy} !== 3'b000) begin n_err++; $display("FAIL reset_ld_busy: got %b want 000", {LD_time, LD_alarm, busy}); end
        apply_reset();
    endtask

    task automatic test_time_ok();
        // T: accept
        req_valid0 = 1'b1;
        req_data0  = mk(1'b0, 2'd1, 4'd2, 4'd3, 4'd4);
        #1;
        n_vec++;
        if ({req_ready, busy} !== 3'b010) begin n_err++; $display("FAIL tok_accept: ready/busy %b want 010", {req_ready, busy}); end
        // T+1: CHECK
        tick();
        req_valid0 = 1'b0;
        #1;
        n_vec++;
        if ({req_ready, busy, LD_time, LD_alarm} !== 5'b00100) begin n_err++; $display("FAIL tok_check: got %b want 00100", {req_ready, busy, LD_time, LD_alarm}); end
        // T+2: LOAD
        tick();
        #1;
        n_vec++;
        if ({LD_time, LD_alarm} !== 2'b10) begin n_err++; $display("FAIL tok_ld: got %b want 10", {LD_time, LD_alarm}); end
        n_vec++;
        if ({H_in1, H_in0, M_in1, M_in0} !== {2'd1, 4'd2, 4'd3, 4'd4}) begin n_err++; $display("FAIL tok_hin: got %h want %h", {H_in1, H_in0, M_in1, M_in0}, {2'd1, 4'd2, 4'd3, 4'd4}); end
        // T+3: VERIFY, clock now reads back the loaded value
        tick();
        H_out1 = 2'd1; H_out0 = 4'd2; M_out1 = 4'd3; M_out0 = 4'd4;
        #1;
        n_vec++;
        if ({LD_time, resp_valid, H_in1} !== 5'b0_00_01) begin n_err++; $display("FAIL tok_verify: got %b want 00001", {LD_time, resp_valid, H_in1}); end
        // T+4: RESP
        tick();
        #1;
        n_vec++;
        if ({resp_valid, resp_code} !== 4'b01_00) begin n_err++; $display("FAIL tok_resp: got %b want 0100", {resp_valid, resp_code}); end
        n_vec++;
        if ({H_in1, H_in0, M_in1, M_in0} !== 14'd0) begin n_err++; $display("FAIL tok_hin_resp: got %h want 0", {H_in1, H_in0, M_in1, M_in0}); end
        // T+5: IDLE
        tick();
        #1;
        n_vec++;
        if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL tok_idle: got %b want 000", {resp_valid, busy}); end
    endtask

    task automatic test_both();
        apply_reset();
        req_valid0 = 1'b1; req_data0 = mk(1'b1, 2'd0, 4'd6, 4'd3, 4'd0);
        req_valid1 = 1'b1; req_data1 = mk(1'b0, 2'd2, 4'd3, 4'd5, 4'd9);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL both_first: got %b want 01", req_ready); end
        tick();
        req_valid0 = 1'b0;
        #1;
        n_vec++;
        if (req_ready !== 2'b00) begin n_err++; $display("FAIL both_check_ready: got %b want 00", req_ready); end
        tick();
        #1;
        n_vec++;
        if ({LD_alarm, LD_time, H_in0, M_in1} !== {1'b1, 1'b0, 4'd6, 4'd3}) begin n_err++; $display("FAIL both_alarm_ld: got %h want %h", {LD_alarm, LD_time, H_in0, M_in1}, {1'b1, 1'b0, 4'd6, 4'd3}); end
        tick();
        #1;
        n_vec++;
        if ({resp_valid, resp_code, req_ready} !== 6'b01_00_00) begin n_err++; $display("FAIL both_resp0: got %b want 010000", {resp_valid, resp_code, req_ready}); end
        tick();
        H_out1 = 2'd2; H_out0 = 4'd3; M_out1 = 4'd5; M_out0 = 4'd9;
        #1;
        n_vec++;
        if (req_ready !== 2'b10) begin n_err++; $display("FAIL both_second: got %b want 10", req_ready); end
        tick();
        req_valid1 = 1'b0;
        tick();
        #1;
        n_vec++;
        if ({LD_time, LD_alarm, H_in1, M_in0} !== {1'b1, 1'b0, 2'd2, 4'd9}) begin n_err++; $display("FAIL both_time_ld: got %h want %h", {LD_time, LD_alarm, H_in1, M_in0}, {1'b1, 1'b0, 2'd2, 4'd9}); end
        tick();
        tick();
        #1;
        n_vec++;
        if ({resp_valid, resp_code} !== 4'b10_00) begin n_err++; $display("FAIL both_resp1: got %b want 1000", {resp_valid, resp_code}); end
        tick();
    endtask

    task automatic test_range();
        req_valid0 = 1'b1; req_data0 = mk(1'b0, 2'd2, 4'd4, 4'd0, 4'd0);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL rng_acc0: got %b want 01", req_ready); end
        tick();
        req_valid0 = 1'b0;
        #1;
        n_vec++;
        if ({busy, LD_time, LD_alarm, resp_valid} !== 5'b10000) begin n_err++; $display("FAIL rng_check0: got %b want 10000", {busy, LD_time, LD_alarm, resp_valid}); end
        tick();
        #1;
        n_vec++;
        if ({resp_valid, resp_code, LD_time, LD_alarm} !== 6'b01_01_00) begin n_err++; $display("FAIL rng_2400: got %b want 010100", {resp_valid, resp_code, LD_time, LD_alarm}); end
        tick();
        req_valid1 = 1'b1; req_data1 = mk(1'b0, 2'd0, 4'd7, 4'd6, 4'd0);
        #1;
        n_vec++;
        if (req_ready !== 2'b10) begin n_err++; $display("FAIL rng_acc1: got %b want 10", req_ready); end
        tick();
        req_valid1 = 1'b0;
        tick();
        #1;
        n_vec++;
        if ({resp_valid, resp_code, LD_time, LD_alarm} !== 6'b10_01_00) begin n_err++; $display("FAIL rng_0760: got %b want 100100", {resp_valid, resp_code, LD_time, LD_alarm}); end
        tick();
    endtask

    task automatic test_timeout();
        H_out1 = '0; H_out0 = '0; M_out1 = '0; M_out0 = '0;
        req_valid0 = 1'b1; req_data0 = mk(1'b0, 2'd0, 4'd8, 4'd1, 4'd5);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL to_accept: got %b want 01", req_ready); end
        tick();
        req_valid0 = 1'b0;
        tick();
        #1;
        n_vec++;
        if (LD_time !== 1'b1) begin n_err++; $display("FAIL to_ld: got %b want 1", LD_time); end
        for (int i = 0; i < int'(TIMEOUT); i++) begin
            tick();
            #1;
            n_vec++;
            if ({resp_valid, busy, H_in0, M_in0} !== {2'b00, 1'b1, 4'd8, 4'd5}) begin
                n_err++;
                $display("FAIL to_verify_%0d: got %h want %h", i, {resp_valid, busy, H_in0, M_in0}, {2'b00, 1'b1, 4'd8, 4'd5});
            end
        end
        tick();
        #1;
        n_vec++;
        if ({resp_valid, resp_code} !== 4'b01_10) begin n_err++; $display("FAIL to_resp: got %b want 0110", {resp_valid, resp_code}); end
        tick();
    endtask

    task automatic test_reset_mid();
        apply_reset();
        // Grant requester 0 so the pointer moves to 1 before the abort
        req_valid0 = 1'b1; req_data0 = mk(1'b0, 2'd1, 4'd0, 4'd0, 4'd0);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL rm_accept: got %b want 01", req_ready); end
        tick();
        req_valid0 = 1'b0;
        tick();
        tick();
        #1;
        n_vec++;
        if ({busy, H_in1} !== 3'b1_01) begin n_err++; $display("FAIL rm_in_verify: got %b want 101", {busy, H_in1}); end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({req_ready, resp_valid, resp_code, LD_time, LD_alarm, busy, H_in1, H_in0, M_in1, M_in0} !== '0) begin
            n_err++;
            $display("FAIL rm_async: got %h want 0", {req_ready, resp_valid, resp_code, LD_time, LD_alarm, busy, H_in1, H_in0, M_in1, M_in0});
        end
        tick();
        reset = 1'b0;
        tick();
        #1;
        n_vec++;
        if ({resp_valid, busy} !== 3'b000) begin n_err++; $display("FAIL rm_no_resp: got %b want 000", {resp_valid, busy}); end
        req_valid0 = 1'b1; req_data0 = mk(1'b0, 2'd1, 4'd1, 4'd1, 4'd1);
        req_valid1 = 1'b1; req_data1 = mk(1'b0, 2'd0, 4'd1, 4'd1, 4'd1);
        #1;
        n_vec++;
        if (req_ready !== 2'b01) begin n_err++; $display("FAIL rm_ptr_reset: got %b want 01", req_ready); end
        tick();
        req_valid0 = 1'b0; req_valid1 = 1'b0;
        tick();
        #1;
        n_vec++;
        if (LD_time !== 1'b1) begin n_err++; $display("FAIL rm_load: got %b want 1", LD_time); end
        reset = 1'b1;
        #1;
        n_vec++;
        if ({LD_time, LD_alarm, H_in1, H_in0} !== 8'd0) begin n_err++; $display("FAIL rm_ld_drop: got %h want 0", {LD_time, LD_alarm, H_in1, H_in0}); end
        apply_reset();
    endtask

    initial begin
        test_reset();
        test_time_ok();
        test_both();
        test_range();
        test_timeout();
        test_reset_mid();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

endmodule
`default_nettype wire
